// File: rtl/dtc_pkg.sv
// dtc_pkg: DTC link framing words and receiver states, shared by the rx and tx ends
package dtc_pkg;
   localparam logic [15:0] W_SYNC = 16'hBC50;
   localparam logic [15:0] W_RPL  = 16'hF7F7;
   localparam logic [15:0] W_STS  = 16'hDCDC;
   localparam logic [15:0] W_EVT  = 16'h5C5C;
   localparam logic [15:0] W_TRL  = 16'hC5D5;
   typedef logic [2:0] rx_state_t;
   localparam rx_state_t ST_HUNT  = 3'd0;
   localparam rx_state_t ST_ALIGN = 3'd1;
   localparam rx_state_t ST_IDLE  = 3'd2;
   localparam rx_state_t ST_EVT   = 3'd3;
   localparam rx_state_t ST_RPL   = 3'd4;
   localparam rx_state_t ST_STS   = 3'd5;
endpackage

// File: rtl/dtc_rx_align.sv
// dtc_rx_align: DDR capture, nibble shifter and sync-word alignment for the DTC receiver
module dtc_rx_align import dtc_pkg::*; #(
   parameter int SYNC_LOCK = 4
) (
   input  logic        dtc_clk,
   input  logic        rst,
   input  logic        dtc_data,
   input  logic        dtc_return,
   input  logic        relock,
   output logic [15:0] word,
   output logic        wstb,
   output logic        locked
);
   logic d_r, r_r, d_f, r_f, q_dr, q_rr, q_df, q_rf;
   logic [15:0] sr;
   logic [1:0] ph, lock_ph;
   logic [7:0] sync_cnt;
   rx_state_t st;
   // same-edge-pipelined IDDR pair: rise and fall halves leave together on the next rising edge
   always_ff @(posedge dtc_clk) {d_r, r_r} <= {dtc_data, dtc_return};
   always_ff @(negedge dtc_clk) {d_f, r_f} <= {dtc_data, dtc_return};
   always_ff @(posedge dtc_clk) {q_rf, q_df, q_rr, q_dr} <= {r_f, d_f, r_r, d_r};
   assign word = sr;
   assign wstb = ph == lock_ph;
   assign locked = st == ST_IDLE;
   always_ff @(posedge dtc_clk)
      if (rst) begin
         sr <= '0;
         ph <= '0;
         lock_ph <= '0;
         sync_cnt <= '0;
         st <= ST_HUNT;
      end else begin
         sr <= {q_rf, q_df, q_rr, q_dr, sr[15:4]};
         ph <= ph + 2'd1;
         if (st == ST_HUNT && sr == W_SYNC) begin
            lock_ph <= ph;
            sync_cnt <= 8'd1;
            st <= SYNC_LOCK == 1 ? ST_IDLE : ST_ALIGN;
         end else if (st == ST_ALIGN && wstb) begin
            sync_cnt <= sync_cnt + 8'd1;
            st <= sr != W_SYNC ? ST_HUNT : sync_cnt + 8'd1 == 8'(SYNC_LOCK) ? ST_IDLE : ST_ALIGN;
         end else if (st == ST_IDLE && relock)
            st <= ST_HUNT;
      end
endmodule

// File: rtl/dtc_rx.sv
// dtc_rx: DTC link receiver, decodes event, register-reply and status frames from aligned words
module dtc_rx import dtc_pkg::*; #(
   parameter int SYNC_LOCK     = 4,
   parameter int MAX_EVT_WORDS = 2624
) (
   input  logic        dtc_clk,
   input  logic        rst,
   input  logic        dtc_data,
   input  logic        dtc_return,
   output logic        locked,
   output logic        evt_start,
   output logic        evt_wr,
   output logic [11:0] evt_idx,
   output logic [11:0] evt_data,
   output logic        evt_done,
   output logic        rpl_vld,
   output logic [31:0] rpl_addr,
   output logic [31:0] rpl_data,
   output logic        sts_vld,
   output logic [15:0] sts_word,
   output logic        err
);
   logic [15:0] word;
   logic wstb, stb, adc, bad;
   rx_state_t st;
   logic [11:0] cnt;
   logic [1:0] rcnt;
   logic [47:0] rbuf;
   dtc_rx_align #(.SYNC_LOCK(SYNC_LOCK)) u_align (
      .dtc_clk(dtc_clk), .rst(rst), .dtc_data(dtc_data), .dtc_return(dtc_return),
      .relock(bad), .word(word), .wstb(wstb), .locked(locked)
   );
   assign stb = wstb && locked;
   assign adc = word[15:12] == 4'h0;
   assign bad = stb && (st == ST_IDLE ? !(word inside {W_SYNC, W_TRL, W_EVT, W_RPL, W_STS}) :
                        st == ST_EVT && (adc ? cnt == 12'(MAX_EVT_WORDS) : word != W_TRL));
   always_ff @(posedge dtc_clk)
      if (rst) begin
         st <= ST_IDLE;
         {evt_start, evt_wr, evt_done, rpl_vld, sts_vld, err} <= '0;
         {evt_idx, evt_data, cnt, rcnt, rbuf} <= '0;
         {rpl_addr, rpl_data, sts_word} <= '0;
      end else begin
         {evt_start, evt_wr, evt_done, rpl_vld, sts_vld} <= '0;
         err <= bad;
         // losing alignment abandons any frame in progress without a completion pulse
         if (!locked || bad)
            st <= ST_IDLE;
         else if (stb)
            case (st)
               ST_IDLE: begin
                  evt_start <= word == W_EVT;
                  if (word == W_EVT) evt_idx <= '0;
                  cnt <= '0;
                  rcnt <= '0;
                  st <= word == W_EVT ? ST_EVT : word == W_RPL ? ST_RPL : word == W_STS ? ST_STS : ST_IDLE;
               end
               ST_EVT:
                  if (adc) begin
                     evt_wr <= 1'b1;
                     evt_data <= word[11:0];
                     evt_idx <= cnt;
                     cnt <= cnt + 12'd1;
                  end else begin
                     evt_done <= 1'b1;
                     st <= ST_IDLE;
                  end
               ST_RPL: begin
                  rbuf <= {rbuf[31:0], word};
                  rcnt <= rcnt + 2'd1;
                  if (rcnt == 2'd3) begin
                     rpl_vld <= 1'b1;
                     rpl_addr <= rbuf[47:16];
                     rpl_data <= {rbuf[15:0], word};
                     st <= ST_IDLE;
                  end
               end
               ST_STS: begin
                  sts_vld <= 1'b1;
                  sts_word <= word;
                  st <= ST_IDLE;
               end
               default: st <= ST_IDLE;
            endcase
      end
endmodule

// File: tb/tb_dtc_rx.sv
// tb_dtc_rx: directed self-checking bench for the DTC link receiver
module tb_dtc_rx;
   logic dtc_clk = 1'b0, rst = 1'b1, dtc_data = 1'b0, dtc_return = 1'b0;
   logic locked, evt_start, evt_wr, evt_done, rpl_vld, sts_vld, err;
   logic [11:0] evt_idx, evt_data;
   logic [31:0] rpl_addr, rpl_data;
   logic [15:0] sts_word;
   int checks = 0, failures = 0;
   int n_start = 0, n_wr = 0, n_done = 0, n_rpl = 0, n_sts = 0, n_err = 0;
   logic [11:0] wr_idx[$], wr_dat[$];

   always #5 dtc_clk = ~dtc_clk;

   dtc_rx dut (
      .dtc_clk(dtc_clk), .rst(rst), .dtc_data(dtc_data), .dtc_return(dtc_return),
      .locked(locked), .evt_start(evt_start), .evt_wr(evt_wr), .evt_idx(evt_idx),
      .evt_data(evt_data), .evt_done(evt_done), .rpl_vld(rpl_vld), .rpl_addr(rpl_addr),
      .rpl_data(rpl_data), .sts_vld(sts_vld), .sts_word(sts_word), .err(err)
   );

   always @(negedge dtc_clk) begin
      if (evt_start) n_start++;
      if (evt_done) n_done++;
      if (rpl_vld) n_rpl++;
      if (sts_vld) n_sts++;
      if (err) n_err++;
      if (evt_wr) begin
         n_wr++;
         wr_idx.push_back(evt_idx);
         wr_dat.push_back(evt_data);
      end
   end

   task automatic send_nib(input logic [3:0] n);
      @(negedge dtc_clk);
      #1;
      dtc_data = n[0];
      dtc_return = n[1];
      @(posedge dtc_clk);
      #1;
      dtc_data = n[2];
      dtc_return = n[3];
   endtask

   task automatic send_word(input logic [15:0] w);
      for (int i = 0; i < 4; i++) send_nib(w[4*i +: 4]);
   endtask

   task automatic do_reset;
      rst = 1'b1;
      dtc_data = 1'b0;
      dtc_return = 1'b0;
      repeat (3) @(posedge dtc_clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_reset;
      do_reset();
      checks++;
      if ({locked, evt_start, evt_wr, evt_idx, evt_data, evt_done, rpl_vld, rpl_addr, rpl_data,
           sts_vld, sts_word, err} !== '0) begin
         failures++;
         $display("FAIL reset_outputs: locked=%b evt_idx=%h rpl_addr=%h sts_word=%h err=%b, all required 0",
                  locked, evt_idx, rpl_addr, sts_word, err);
      end
   endtask

   task automatic test_phase(input int k);
      int b_sts, b_err, b_oth;
      do_reset();
      b_sts = n_sts;
      b_err = n_err;
      b_oth = n_start + n_wr + n_done + n_rpl;
      repeat (k) send_nib(4'h0);
      repeat (4) send_word(16'hBC50);
      send_nib(4'h0);
      send_nib(4'h5);
      checks++;
      if (locked !== 1'b0) begin
         failures++;
         $display("FAIL phase%0d_early_lock: locked=%b required 0", k, locked);
      end
      send_nib(4'hC);
      checks++;
      if (locked !== 1'b1) begin
         failures++;
         $display("FAIL phase%0d_lock: locked=%b required 1", k, locked);
      end
      send_nib(4'hB);
      send_word(16'hDCDC);
      send_word(16'h00A0 | 16'(k));
      send_word(16'hBC50);
      send_word(16'hBC50);
      checks++;
      if (n_sts - b_sts !== 1 || sts_word !== (16'h00A0 | 16'(k))) begin
         failures++;
         $display("FAIL phase%0d_sts: count=%0d word=%h required 1 and %h", k, n_sts - b_sts, sts_word,
                  16'h00A0 | 16'(k));
      end
      checks++;
      if (n_err - b_err !== 0 || n_start + n_wr + n_done + n_rpl - b_oth !== 0) begin
         failures++;
         $display("FAIL phase%0d_spurious: err=%0d other=%0d required 0 and 0", k, n_err - b_err,
                  n_start + n_wr + n_done + n_rpl - b_oth);
      end
   endtask

   task automatic test_event;
      int bs = n_start, bw = n_wr, bd = n_done, be = n_err;
      send_word(16'h5C5C);
      send_word(16'h0ABC);
      send_word(16'h0123);
      send_word(16'hC5D5);
      send_word(16'hBC50);
      send_word(16'hBC50);
      checks++;
      if (n_start - bs !== 1 || n_wr - bw !== 2 || n_done - bd !== 1 || n_err - be !== 0) begin
         failures++;
         $display("FAIL event_counts: start=%0d wr=%0d done=%0d err=%0d required 1 2 1 0",
                  n_start - bs, n_wr - bw, n_done - bd, n_err - be);
      end
      checks++;
      if (wr_idx[bw] !== 12'd0 || wr_dat[bw] !== 12'hABC) begin
         failures++;
         $display("FAIL event_word0: idx=%0d data=%h required 0 abc", wr_idx[bw], wr_dat[bw]);
      end
      checks++;
      if (wr_idx[bw+1] !== 12'd1 || wr_dat[bw+1] !== 12'h123) begin
         failures++;
         $display("FAIL event_word1: idx=%0d data=%h required 1 123", wr_idx[bw+1], wr_dat[bw+1]);
      end
      checks++;
      if (locked !== 1'b1) begin
         failures++;
         $display("FAIL event_locked: locked=%b required 1", locked);
      end
   endtask

   task automatic test_reply;
      int br = n_rpl, be = n_err;
      send_word(16'hF7F7);
      send_word(16'h1234);
      send_word(16'h5678);
      send_word(16'h9ABC);
      send_word(16'hDEF0);
      send_word(16'hBC50);
      send_word(16'hBC50);
      checks++;
      if (n_rpl - br !== 1 || n_err - be !== 0) begin
         failures++;
         $display("FAIL reply_count: rpl=%0d err=%0d required 1 0", n_rpl - br, n_err - be);
      end
      checks++;
      if (rpl_addr !== 32'h12345678 || rpl_data !== 32'h9ABCDEF0) begin
         failures++;
         $display("FAIL reply_fields: addr=%h data=%h required 12345678 9abcdef0", rpl_addr, rpl_data);
      end
   endtask

   task automatic test_status_err;
      int bs = n_sts, be = n_err;
      send_word(16'hDCDC);
      send_word(16'h00A5);
      send_word(16'hBC50);
      send_word(16'hBC50);
      checks++;
      if (n_sts - bs !== 1 || sts_word !== 16'h00A5 || n_err - be !== 0) begin
         failures++;
         $display("FAIL status: count=%0d word=%h err=%0d required 1 00a5 0", n_sts - bs, sts_word, n_err - be);
      end
      send_word(16'h1111);
      send_word(16'hBC50);
      checks++;
      if (n_err - be !== 1 || locked !== 1'b0) begin
         failures++;
         $display("FAIL bad_word: err=%0d locked=%b required 1 0", n_err - be, locked);
      end
   endtask

   task automatic test_overflow;
      int bs, bw, bd, be;
      repeat (6) send_word(16'hBC50);
      checks++;
      if (locked !== 1'b1) begin
         failures++;
         $display("FAIL relock_after_err: locked=%b required 1", locked);
      end
      bs = n_start;
      bw = n_wr;
      bd = n_done;
      be = n_err;
      send_word(16'h5C5C);
      for (int i = 0; i <= 2624; i++) send_word({4'h0, 12'(i)});
      send_word(16'hC5D5);
      repeat (6) send_word(16'hBC50);
      checks++;
      if (n_start - bs !== 1 || n_wr - bw !== 2624 || n_done - bd !== 0 || n_err - be !== 1) begin
         failures++;
         $display("FAIL overflow_counts: start=%0d wr=%0d done=%0d err=%0d required 1 2624 0 1",
                  n_start - bs, n_wr - bw, n_done - bd, n_err - be);
      end
      checks++;
      if (wr_idx[bw] !== 12'd0 || wr_idx[bw+2623] !== 12'd2623 || wr_dat[bw+2623] !== 12'hA3F) begin
         failures++;
         $display("FAIL overflow_words: first_idx=%0d last_idx=%0d last_data=%h required 0 2623 a3f",
                  wr_idx[bw], wr_idx[bw+2623], wr_dat[bw+2623]);
      end
      checks++;
      if (locked !== 1'b1) begin
         failures++;
         $display("FAIL overflow_relock: locked=%b required 1", locked);
      end
   endtask

   task automatic test_reset_mid_reply;
      int br = n_rpl;
      send_word(16'hF7F7);
      send_word(16'h1234);
      send_word(16'h5678);
      do_reset();
      checks++;
      if ({locked, evt_idx, evt_data, rpl_vld, rpl_addr, rpl_data, sts_vld, sts_word, err} !== '0) begin
         failures++;
         $display("FAIL mid_reset_outputs: locked=%b evt_data=%h rpl_addr=%h rpl_data=%h sts_word=%h required all 0",
                  locked, evt_data, rpl_addr, rpl_data, sts_word);
      end
      send_word(16'h9ABC);
      send_word(16'hDEF0);
      send_word(16'hBC50);
      send_word(16'hBC50);
      checks++;
      if (n_rpl - br !== 0) begin
         failures++;
         $display("FAIL mid_reset_no_reply: rpl=%0d required 0", n_rpl - br);
      end
   endtask

   initial begin
      test_reset();
      for (int k = 0; k < 4; k++) test_phase(k);
      test_event();
      test_reply();
      test_status_err();
      test_overflow();
      test_reset_mid_reply();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/dtc_rx.md
# dtc_rx

Receiving end of the DTC serial link. The block captures the 2-wire DDR stream (`dtc_data`, `dtc_return`) and recovers 16-bit words, locking onto the idle sync word. It then decodes event, register-reply and status frames into parallel outputs for the readout controller. It is the counterpart of the FEC-side DTC transmitter and uses the same framing constants.

## Interface
Parameters:
- `SYNC_LOCK`, default 4: consecutive aligned sync words required to declare lock.
- `MAX_EVT_WORDS`, default 2624: maximum ADC words per event (64 ch × 41 samples).

Ports (clock and reset first):
- `dtc_clk`  in  1  link clock; rising edge carries the low half-nibble, falling edge the high half-nibble.
- `rst`  in  1  reset; synchronous, active-high.
- `dtc_data`  in  1  DDR line, pin-level.
- `dtc_return`  in  1  DDR line, pin-level.
- `locked`  out  1  word alignment established.
- `evt_start`  out  1  one-cycle pulse when the event header is decoded.
- `evt_wr`  out  1  one-cycle pulse per ADC word.
- `evt_idx`  out  12  index of the current ADC word, 0-based.
- `evt_data`  out  12  ADC sample.
- `evt_done`  out  1  one-cycle pulse when the trailer is decoded.
- `rpl_vld`  out  1  one-cycle pulse; a register reply is complete.
- `rpl_addr`  out  32  reply address.
- `rpl_data`  out  32  reply data.
- `sts_vld`  out  1  one-cycle pulse; a status word is complete.
- `sts_word`  out  16  status word.
- `err`  out  1  one-cycle pulse on a protocol error.

## Operation
- Capture: each line uses an IDDR in SAME_EDGE_PIPELINED mode. The nibble per cycle is {return_fall, data_fall, return_rise, data_rise}, bit 0 first.
- Shift register: `sr <= {nibble, sr[15:4]}` every cycle. Words are sent LSB nibble first.
- Constants:
  - sync 0xBC50
  - reply header 0xF7F7
  - status header 0xDCDC
  - event header 0x5C5C
  - trailer 0xC5D5
  - ADC word = {4'h0, sample[11:0]}
- Word phase: a free-running 2-bit counter `ph`. The word strobe `wstb` is asserted when `ph == lock_ph`.
- States:
  - `HUNT`: `sr == 0xBC50` in any cycle → `lock_ph` ← current `ph`, `sync_cnt` ← 1, go to `ALIGN`.
  - `ALIGN`: on each `wstb`, sync increments `sync_cnt`; any other word → `HUNT`. When `sync_cnt == SYNC_LOCK`, go to `IDLE` and set `locked`.
  - `IDLE` (`locked`=1), on `wstb`:
    - sync or trailer: stay.
    - 0x5C5C: `evt_start`, clear `evt_idx`, go to `EVT`.
    - 0xF7F7: go to `RPL`, word count ← 0.
    - 0xDCDC: go to `STS`.
    - any other word: `err`, go to `HUNT`.
  - `EVT`, on `wstb`:
    - word[15:12] == 0: `evt_wr` with `evt_data` = word[11:0] and the current `evt_idx`, then increment `evt_idx`.
    - 0xC5D5: `evt_done`, go to `IDLE`.
    - any other word: `err`, go to `HUNT`.
    - ADC word arriving when `evt_idx == MAX_EVT_WORDS`: `err`, go to `HUNT`, no `evt_wr`.
  - `RPL`: captures addr_hi, addr_lo, data_hi, data_lo in that order. `rpl_vld` fires after data_lo; go to `IDLE`. Any field value is legal.
  - `STS`: next word → `sts_word`, `sts_vld`, go to `IDLE`.
- Leaving lock: `locked` drops whenever the state enters `HUNT`. A frame in progress is abandoned: no `evt_done` and no `rpl_vld`.
- Held outputs: `rpl_addr`, `rpl_data`, `sts_word` and `evt_data` hold until overwritten.

## Timing
- Reset: state `HUNT`. All outputs 0, all counters 0. The IDDRs are not reset. A reset mid-frame discards the frame with no pulse.
- Latency: the last nibble of a word is present at the pins on rising/falling edge N. The corresponding pulse (`evt_wr`, `rpl_vld`, `sts_vld`, `evt_done`, `err`) is high in the cycle after edge N+3. Latency is fixed, so pulses are at least 4 cycles apart.
- `locked` rises in the same cycle as the decode of the `SYNC_LOCK`-th sync.
- `evt_idx` is 12 bits and never wraps (bounded by `MAX_EVT_WORDS`).
- No backpressure. Consumers must accept one word per 4 cycles.

## Structure
- Package `dtc_pkg`: the five word constants and the receiver state enum. The transmitter also imports this package.
- Sub-module `dtc_rx_align`: IDDR pair, nibble shift register, `ph`, and `HUNT`/`ALIGN` lock logic. It outputs `word[15:0]`, `wstb`, `locked`, and takes a `relock` input driven by the frame decoder on error. The frame decoder state machine lives in `dtc_rx`.

## Test plan
- Idle stream of 0xBC50 at each of the 4 nibble phase offsets → `locked`=1 after exactly 4 syncs at the correct phase; no other pulses.
- Locked; send 0x5C5C, 0x0ABC, 0x0123, 0xC5D5 → `evt_start`; `evt_wr` ×2 with (idx 0, 0xABC) then (idx 1, 0x123); `evt_done`; back in `IDLE`.
- Locked; send 0xF7F7, 0x1234, 0x5678, 0x9ABC, 0xDEF0 → one `rpl_vld` with `rpl_addr`=0x12345678, `rpl_data`=0x9ABCDEF0.
- Locked; send 0xDCDC, 0x00A5 → `sts_vld` with `sts_word`=0x00A5. Then 0x1111 in `IDLE` → `err`, `locked`=0.
- Event with 2625 ADC words → `err` at word 2625, no `evt_done`, relock on following syncs. Separately, `rst` asserted mid-reply → no `rpl_vld`, all outputs 0.
